// File: rtl/myfilter_dp.sv
// Command-driven FIR datapath: delay line, tap-serial multiply-accumulate,
// saturating result register with a valid/ready output handshake.
module myfilter_dp #(
  parameter int DATABITS = 16,
  parameter int TAPS = 4,
  parameter logic signed [DATABITS-1:0] COEFS [TAPS] = '{1, 2, 3, 4},
  parameter int UL_LIMIT = 1000,
  parameter int DL_LIMIT = -1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          cmd_in,
  input  logic [DATABITS-1:0] data_in,
  input  logic                extready_in,
  output logic [DATABITS-1:0] q_out,
  output logic                valid_out,
  output logic                ul_out,
  output logic                dl_out,
  output logic                overrun_out
);

  localparam int ACC_W  = 2*DATABITS + $clog2(TAPS);
  localparam int IDX_W  = $clog2(TAPS) + 1;
  localparam int SEL_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = 2*DATABITS;

  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(TAPS);
  localparam logic signed [ACC_W-1:0] UL_A = ACC_W'(UL_LIMIT);
  localparam logic signed [ACC_W-1:0] DL_A = ACC_W'(DL_LIMIT);
  localparam logic signed [ACC_W-1:0] Q_MAX =
    {{(ACC_W-DATABITS+1){1'b0}}, {(DATABITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN =
    {{(ACC_W-DATABITS+1){1'b1}}, {(DATABITS-1){1'b0}}};

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_CLR  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_MAC  = 3'd3,
    CMD_OUT  = 3'd4
  } dp_cmd_t;

  function automatic logic signed [DATABITS-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > Q_MAX)
      return Q_MAX[DATABITS-1:0];
    else if (a < Q_MIN)
      return Q_MIN[DATABITS-1:0];
    else
      return a[DATABITS-1:0];
  endfunction

  logic signed [DATABITS-1:0] x [TAPS];
  logic signed [ACC_W-1:0]    acc;
  logic [IDX_W-1:0]           idx;
  logic [SEL_W-1:0]           idx_sel;
  logic signed [PROD_W-1:0]   prod;
  logic                       consume;

  assign idx_sel = SEL_W'(idx);
  assign prod    = PROD_W'(x[idx_sel]) * PROD_W'(COEFS[idx_sel]);
  assign consume = valid_out & extready_in;

  // Delay line, accumulator and tap index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      acc <= '0;
      idx <= '0;
    end else begin
      case (cmd_in)
        CMD_CLR: begin
          acc <= '0;
          idx <= '0;
        end
        CMD_LOAD: begin
          for (int k = TAPS-1; k > 0; k--) x[k] <= x[k-1];
          x[0] <= data_in;
          idx  <= '0;
        end
        CMD_MAC: begin
          // Saturates at TAPS: extra MACs are harmless no-ops.
          if (idx < IDX_END) begin
            acc <= acc + ACC_W'(prod);
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result register and handshake; a consume in the same cycle frees the slot for OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_out       <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (cmd_in == CMD_OUT) begin
        if (!valid_out || consume) begin
          q_out     <= sat(acc);
          valid_out <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (consume) begin
        valid_out <= 1'b0;
      end
    end
  end

  assign ul_out = (acc > UL_A);
  assign dl_out = (acc < DL_A);

endmodule

// File: tb/tb_myfilter_dp.sv
// Directed bench for myfilter_dp: filter arithmetic, handshake, limits,
// saturation, overrun and asynchronous reset, with hand-computed expectations.
module tb_myfilter_dp;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] MAC  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cmd_in;
  logic [15:0] data_in;
  logic        extready_in;
  logic [15:0] q_out;
  logic        valid_out;
  logic        ul_out;
  logic        dl_out;
  logic        overrun_out;

  int total = 0;
  int bad = 0;

  myfilter_dp dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_in      (cmd_in),
    .data_in     (data_in),
    .extready_in (extready_in),
    .q_out       (q_out),
    .valid_out   (valid_out),
    .ul_out      (ul_out),
    .dl_out      (dl_out),
    .overrun_out (overrun_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic [15:0] d);
    cmd_in  = c;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    extready_in = 1'b1;
    step(NOP, 16'd0);
    extready_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_in = NOP;
    data_in = '0;
    extready_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_q", q_out, 16'd0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_ovr", overrun_out, 1'b0);
    chk("rst_ul", ul_out, 1'b0);
    chk("rst_dl", dl_out, 1'b0);
    rst = 1'b0;

    // Basic filter: x = {40,30,20,10}, expected 200
    step(LOAD, 16'd10);
    step(LOAD, 16'd20);
    step(LOAD, 16'd30);
    step(LOAD, 16'd40);
    step(CLR, 16'd0);
    step(MAC, 16'd0);
    step(MAC, 16'd0);
    step(MAC, 16'd0);
    step(MAC, 16'd0);
    chk("filt_ul", ul_out, 1'b0);
    chk("filt_dl", dl_out, 1'b0);
    step(OUT, 16'd0);
    chk("filt_q", q_out, 16'd200);
    chk("filt_valid", valid_out, 1'b1);
    step(MAC, 16'd0);
    chk("mac5_valid", valid_out, 1'b1);

    // Handshake: hold off consumer, then one-cycle ready
    for (int i = 0; i < 5; i++) begin
      step(NOP, 16'd0);
      chk("hold_q", q_out, 16'd200);
      chk("hold_valid", valid_out, 1'b1);
    end
    drain();
    chk("consume_valid", valid_out, 1'b0);
    chk("consume_ovr", overrun_out, 1'b0);
    step(OUT, 16'd0);
    chk("mac5_acc_q", q_out, 16'd200);
    chk("mac5_acc_valid", valid_out, 1'b1);
    drain();

    // Same filter with NOP and illegal codes interleaved
    step(LOAD, 16'd10);
    step(3'd5, 16'd99);
    step(LOAD, 16'd20);
    step(NOP, 16'd77);
    step(LOAD, 16'd30);
    step(3'd6, 16'd55);
    step(LOAD, 16'd40);
    step(3'd7, 16'd0);
    step(CLR, 16'd0);
    step(NOP, 16'd0);
    step(MAC, 16'd0);
    step(3'd5, 16'd0);
    step(MAC, 16'd0);
    step(MAC, 16'd0);
    step(3'd7, 16'd0);
    step(MAC, 16'd0);
    step(OUT, 16'd0);
    chk("illegal_q", q_out, 16'd200);
    chk("illegal_valid", valid_out, 1'b1);
    drain();

    // Positive limit and saturation: acc = 327670
    for (int i = 0; i < 4; i++) step(LOAD, 16'd32767);
    step(CLR, 16'd0);
    chk("clr_ul", ul_out, 1'b0);
    for (int i = 0; i < 4; i++) step(MAC, 16'd0);
    chk("pos_ul", ul_out, 1'b1);
    chk("pos_dl", dl_out, 1'b0);
    step(OUT, 16'd0);
    chk("pos_sat_q", q_out, 16'h7fff);
    drain();

    // Negative limit and saturation: acc = -327680
    for (int i = 0; i < 4; i++) step(LOAD, 16'h8000);
    step(CLR, 16'd0);
    for (int i = 0; i < 4; i++) step(MAC, 16'd0);
    chk("neg_dl", dl_out, 1'b1);
    chk("neg_ul", ul_out, 1'b0);
    step(OUT, 16'd0);
    chk("neg_sat_q", q_out, 16'h8000);
    drain();

    // Overrun and consume-then-load: x = {4,3,2,1}, full result 20
    step(LOAD, 16'd1);
    step(LOAD, 16'd2);
    step(LOAD, 16'd3);
    step(LOAD, 16'd4);
    step(CLR, 16'd0);
    for (int i = 0; i < 4; i++) step(MAC, 16'd0);
    step(OUT, 16'd0);
    chk("ovr_first_q", q_out, 16'd20);
    step(CLR, 16'd0);
    extready_in = 1'b1;
    step(OUT, 16'd0);
    extready_in = 1'b0;
    chk("ctl_q", q_out, 16'd0);
    chk("ctl_valid", valid_out, 1'b1);
    chk("ctl_ovr", overrun_out, 1'b0);
    step(MAC, 16'd0);
    step(OUT, 16'd0);
    chk("ovr_flag", overrun_out, 1'b1);
    chk("ovr_q_held", q_out, 16'd0);
    chk("ovr_valid", valid_out, 1'b1);
    step(MAC, 16'd0);
    extready_in = 1'b1;
    step(OUT, 16'd0);
    extready_in = 1'b0;
    chk("ovr_reload_q", q_out, 16'd10);
    chk("ovr_sticky", overrun_out, 1'b1);
    chk("ovr_reload_valid", valid_out, 1'b1);

    // Asynchronous reset mid-MAC: acc = 600*1 + 600*2 = 1800
    step(LOAD, 16'd600);
    step(LOAD, 16'd600);
    step(CLR, 16'd0);
    step(MAC, 16'd0);
    step(MAC, 16'd0);
    chk("pre_rst_ul", ul_out, 1'b1);
    rst = 1'b1;
    #2;
    chk("arst_q", q_out, 16'd0);
    chk("arst_valid", valid_out, 1'b0);
    chk("arst_ovr", overrun_out, 1'b0);
    chk("arst_ul", ul_out, 1'b0);
    chk("arst_dl", dl_out, 1'b0);
    #1;
    rst = 1'b0;
    step(CLR, 16'd0);
    chk("post_rst_valid", valid_out, 1'b0);
    chk("post_rst_ul", ul_out, 1'b0);
    for (int i = 0; i < 4; i++) step(MAC, 16'd0);
    step(OUT, 16'd0);
    chk("post_rst_q", q_out, 16'd0);
    chk("post_rst_out_valid", valid_out, 1'b1);
    drain();
    chk("post_rst_drain", valid_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/myfilter_dp.md
MYFILTER_DP -- requirements
Module: myfilter_dp

Interface
REQ-001 Parameter DATABITS, default 16, signed sample and result width.
REQ-002 Parameter TAPS, default 4, number of delay-line taps and coefficients.
REQ-003 Parameter COEFS, default {1,2,3,4}, signed DATABITS-wide coefficient per tap; index 0 is the first entry.
REQ-004 Parameter UL_LIMIT, default 1000, signed upper-limit threshold on the accumulator.
REQ-005 Parameter DL_LIMIT, default -1000, signed lower-limit threshold on the accumulator.
REQ-006 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1, asynchronous, active-high reset.
REQ-008 Port cmd_in, input, CMDBITS (dp_cmd_t), command from the dpc controller, one per cycle.
REQ-009 Port data_in, input, DATABITS signed, sample consumed by LOAD.
REQ-010 Port extready_in, input, 1, downstream ready for q_out.
REQ-011 Port q_out, output, DATABITS signed, filter result.
REQ-012 Port valid_out, output, 1, q_out holds an unconsumed result.
REQ-013 Port ul_out, output, 1, accumulator above UL_LIMIT; feeds dpc ul_in.
REQ-014 Port dl_out, output, 1, accumulator below DL_LIMIT; feeds dpc dl_in.
REQ-015 Port overrun_out, output, 1, sticky error: OUT issued while valid_out was high.

Function
REQ-016 Encoding SHALL be NOP=0, CLR=1, LOAD=2, MAC=3, OUT=4; codes 5-7 SHALL behave as NOP.
REQ-017 Internal state SHALL be a TAPS-deep delay line x[0..TAPS-1], accumulator acc of 2*DATABITS+clog2(TAPS) bits signed, and tap index idx of clog2(TAPS)+1 bits.
REQ-018 CLR SHALL set acc=0 and idx=0 in one cycle; the delay line is unchanged.
REQ-019 LOAD SHALL shift x[k]<=x[k-1] for all k>0 and x[0]<=data_in, and set idx=0; acc is unchanged.
REQ-020 MAC with idx<TAPS SHALL perform acc<=acc+x[idx]*COEFS[idx] with full-precision signed arithmetic, then idx<=idx+1.
REQ-021 MAC with idx==TAPS SHALL leave acc and idx unchanged (no wrap).
REQ-022 OUT with valid_out low SHALL load q_out with acc saturated to DATABITS signed range [-2^(DATABITS-1), 2^(DATABITS-1)-1] and set valid_out=1 on the next cycle.
REQ-023 OUT with valid_out high SHALL leave q_out unchanged and set overrun_out=1, which stays high until reset.
REQ-024 valid_out SHALL clear on the cycle after a rising edge at which valid_out and extready_in are both 1.
REQ-025 On simultaneous OUT and a consuming extready_in in the same cycle, the cycle SHALL count as consume-then-load: q_out takes the new value, valid_out stays 1, and no overrun is flagged.
REQ-026 q_out SHALL hold stable while valid_out=1 and extready_in=0.
REQ-027 ul_out SHALL equal (acc > UL_LIMIT) and dl_out SHALL equal (acc < DL_LIMIT), decoded from the registered acc; both reflect a command one cycle after it is issued.
REQ-028 Command latency SHALL be exactly one clock for every command; the block never stalls cmd_in.

Reset
REQ-029 On rst=1, immediately and independently of clk, outputs and state SHALL clear: x[*]=0, acc=0, idx=0, q_out=0, valid_out=0, overrun_out=0, ul_out=0, dl_out=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending result; the first command after rst deasserts SHALL execute normally on the next rising edge.

Verification
REQ-031 Reset: assert rst mid-MAC sequence -> all outputs 0 with no clock edge; after release, CLR executes normally.
REQ-032 Filter: LOAD 10,20,30,40 (x[0]=40), CLR, MAC x4, OUT -> q_out=40*1+30*2+20*3+10*4=200, valid_out=1; a fifth MAC leaves acc=200.
REQ-033 Handshake: hold extready_in=0 for 5 cycles after OUT -> q_out stable at 200; extready_in=1 for 1 cycle -> valid_out=0 next cycle.
REQ-034 Limits and saturation: LOAD 32767 x4, CLR, MAC x4 -> acc=327670, ul_out=1, OUT gives q_out=32767; repeat with -32768 -> dl_out=1, q_out=-32768.
REQ-035 Overrun: OUT, then OUT with extready_in=0 -> overrun_out=1 and q_out unchanged; OUT with extready_in=1 -> new q_out loaded, no extra error.
REQ-036 Illegal codes 5-7 and NOP interleaved in REQ-032 sequence -> identical result 200.
